// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with MEM/WB operand forwarding.
// Captures decoded operands and control each cycle. It honours reset, flush and
// stall, in that order of priority. It resolves RAW hazards by selecting forwarded
// results for ALU operand a, operand b and the store data.
// Ports:
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   stall_e, flush_e           - hold / bubble the E-stage registers
//   *_d                        - decode-stage operands and control
//   rd_m, regwrite_m, aluresult_m - MEM-stage writeback candidate
//   rd_w, regwrite_w, result_w    - WB-stage writeback candidate
//   a, b, alucontrol           - ALU inputs
//   writedata_e, rd_e, regwrite_e, valid_e - values passed downstream
//   forward_a, forward_b       - forwarding selects (00 RF, 10 MEM, 01 WB)
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   immext_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [2:0]        alucontrol_d,
    input  logic              alusrc_d,
    input  logic              regwrite_d,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              regwrite_m,
    input  logic [XLEN-1:0]   aluresult_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_w,
    input  logic [XLEN-1:0]   result_w,
    output logic [XLEN-1:0]   a,
    output logic [XLEN-1:0]   b,
    output logic [2:0]        alucontrol,
    output logic [XLEN-1:0]   writedata_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              regwrite_e,
    output logic              valid_e,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic              valid_q;
    logic              regwrite_q;
    logic              alusrc_q;
    logic [2:0]        alucontrol_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [XLEN-1:0]   rd1_q;
    logic [XLEN-1:0]   rd2_q;
    logic [XLEN-1:0]   imm_q;

    logic [1:0]        fwd_a_c;
    logic [1:0]        fwd_b_c;
    logic [XLEN-1:0]   src_a_c;
    logic [XLEN-1:0]   src_b_c;

    // E-stage register set: reset, then flush, then stall, else capture.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            alucontrol_q <= 3'b000;
            rd_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
        end else if (!stall_e) begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            alusrc_q     <= alusrc_d;
            alucontrol_q <= alucontrol_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= immext_d;
        end
    end

    // Forward selection: MEM beats WB, x0 is never a source, bubbles never forward.
    always_comb begin
        fwd_a_c = FWD_RF;
        fwd_b_c = FWD_RF;
        if ((FWD_EN != 0) && valid_q) begin
            if (regwrite_m && (rd_m != '0) && (rd_m == rs1_q)) begin
                fwd_a_c = FWD_MEM;
            end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_q)) begin
                fwd_a_c = FWD_WB;
            end
            if (regwrite_m && (rd_m != '0) && (rd_m == rs2_q)) begin
                fwd_b_c = FWD_MEM;
            end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_q)) begin
                fwd_b_c = FWD_WB;
            end
        end
    end

    // Operand muxes; these stay live during a stall so forwarding tracks M/W.
    always_comb begin
        src_a_c = rd1_q;
        src_b_c = rd2_q;
        case (fwd_a_c)
            FWD_MEM: src_a_c = aluresult_m;
            FWD_WB:  src_a_c = result_w;
            default: src_a_c = rd1_q;
        endcase
        case (fwd_b_c)
            FWD_MEM: src_b_c = aluresult_m;
            FWD_WB:  src_b_c = result_w;
            default: src_b_c = rd2_q;
        endcase
    end

    // A bubble presents zeros and an add to the ALU.
    assign a           = valid_q ? src_a_c : '0;
    assign writedata_e = valid_q ? src_b_c : '0;
    assign b           = !valid_q ? '0 : (alusrc_q ? imm_q : src_b_c);
    assign alucontrol  = valid_q ? alucontrol_q : 3'b000;
    assign rd_e        = rd_q;
    assign regwrite_e  = regwrite_q & valid_q;
    assign valid_e     = valid_q;
    assign forward_a   = fwd_a_c;
    assign forward_b   = fwd_b_c;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU.
- Captures decoded operands and control from the decode stage each cycle.
- Resolves RAW hazards by forwarding results from the MEM and WB stages.
- Drives the ALU's a, b and alucontrol inputs, and passes store data, destination register and write-enable downstream.

Parameters:
- XLEN, 32, datapath width of operands and results.
- REG_AW, 5, register-address width.
- FWD_EN, 1, 1 enables forwarding; 0 forces forward selects to 00 (operands straight from the register file).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall_e  in  1  hold E-stage register contents.
- flush_e  in  1  insert a bubble into the E stage.
- valid_d  in  1  decode stage holds a real instruction.
- rd1_d  in  XLEN  register-file read data for rs1.
- rd2_d  in  XLEN  register-file read data for rs2.
- immext_d  in  XLEN  sign-extended immediate.
- rs1_d  in  REG_AW  source register 1 address.
- rs2_d  in  REG_AW  source register 2 address.
- rd_d  in  REG_AW  destination register address.
- alucontrol_d  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- alusrc_d  in  1  1 selects immext as operand b.
- regwrite_d  in  1  instruction writes rd.
- rd_m  in  REG_AW  MEM-stage destination register.
- regwrite_m  in  1  MEM-stage write enable.
- aluresult_m  in  XLEN  MEM-stage ALU result.
- rd_w  in  REG_AW  WB-stage destination register.
- regwrite_w  in  1  WB-stage write enable.
- result_w  in  XLEN  WB-stage final result.
- a  out  XLEN  ALU operand a.
- b  out  XLEN  ALU operand b.
- alucontrol  out  3  ALU op.
- writedata_e  out  XLEN  forwarded rs2 value, used as store data.
- rd_e  out  REG_AW  E-stage destination register.
- regwrite_e  out  1  E-stage write enable, already gated by valid_e.
- valid_e  out  1  E stage holds a real instruction.
- forward_a  out  2  operand-a select: 00 register file, 10 MEM, 01 WB.
- forward_b  out  2  operand-b select, same encoding as forward_a.

Behaviour:
- Register update priority at each rising clk, highest first:
  - reset: clear all E registers to 0.
  - flush_e: clear all E registers to 0.
  - stall_e: hold all E registers.
  - otherwise: capture all *_d inputs.
- flush_e beats stall_e when both are asserted.
- Reset values: valid_e=0, regwrite_e=0, rd_e=0, alucontrol=000, a=0, b=0, writedata_e=0, forward_a=00, forward_b=00.
- Latency: decode inputs appear on the outputs 1 cycle after capture.
- Forwarding is combinational from the E registers and the M/W inputs. For forward_a:
  - 10 if FWD_EN and regwrite_m and rd_m!=0 and rd_m==rs1_e.
  - else 01 if FWD_EN and regwrite_w and rd_w!=0 and rd_w==rs1_e.
  - else 00.
  - MEM always beats WB when both match.
- forward_b uses the same rules against rs2_e.
- Register x0 is never a forwarding source.
- a = forwarded rs1 value.
- writedata_e = forwarded rs2 value.
- b = immext_e if alusrc_e, else the forwarded rs2 value.
- forward_b is computed even when alusrc_e=1, so store data is still forwarded.
- regwrite_e = regwrite_e_reg AND valid_e.
- When valid_e=0, forward_a and forward_b are forced to 00.
- A bubble (valid_e=0) presents a=0, b=0, alucontrol=000 to the ALU.
- Reset asserted mid-stream discards the E contents on the same edge; no partial state survives.
- During a stall the captured values are held, but the forwarded a and b may change as the M/W inputs change. This is required so forwarding stays correct while the stage is stalled.
- No internal storage beyond the E register set; no internal state machine beyond valid tracking.

Test Plan:
- Reset: reset=1 for 2 cycles with arbitrary *_d inputs -> valid_e=0, regwrite_e=0, a=b=0, alucontrol=000.
- Capture with no hazard: rd1_d=10, rd2_d=15, alucontrol_d=000, alusrc_d=0, valid_d=1, no M/W matches -> next cycle a=10, b=15, forward_a=forward_b=00.
- MEM over WB: rs1_e=5, rd_m=5 with regwrite_m=1 and aluresult_m=0x1234, rd_w=5 with regwrite_w=1 and result_w=0xBEEF -> a=0x1234, forward_a=10. Drop regwrite_m -> a=0xBEEF, forward_a=01.
- x0 never forwarded: rs2_e=0, rd_m=0, regwrite_m=1, aluresult_m=0xFFFF -> forward_b=00, b=rd2 value.
- Immediate with store forwarding: alusrc_d=1, immext_d=0xFFFFFFFC, rs2 matches rd_w with result_w=42 -> b=0xFFFFFFFC, writedata_e=42, forward_b=01.
- Stall and flush:
  - stall_e=1 for 3 cycles -> E contents held.
  - stall_e=1 and flush_e=1 together -> next cycle valid_e=0, regwrite_e=0.
  - reset pulsed mid-stall -> all outputs return to reset values on that edge.
